// File: rtl/pe_incha_window.sv
// pe_incha_window: turns a raster stream of IN_CHANNEL x 8-bit pixels into
// 3x3 windows for a processing element. Pixels land in a 3-row circular line
// buffer. Windows are emitted in raster order, one per pe_ack handshake.
// The optional macro PE_INCHA_WINDOW_PADDING_EN emits every window position
// with zero padding. When it is undefined, only interior windows are emitted.
module pe_incha_window #(
    parameter int IN_WIDTH   = 3,
    parameter int IN_HEIGHT  = 3,
    parameter int IN_CHANNEL = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [8*IN_CHANNEL-1:0]      i_data,
    input  logic                         i_valid,
    output logic                         i_ready,
    output logic [8*IN_CHANNEL*9-1:0]    o_data,
    output logic                         o_valid,
    input  logic                         pe_ack
);
    localparam int PW   = 8*IN_CHANNEL;
    localparam int NPIX = IN_WIDTH*IN_HEIGHT;
    localparam int CW   = $clog2(NPIX+1);
    localparam int XW   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

`ifdef PE_INCHA_WINDOW_PADDING_EN
    localparam int WR0 = 0, WR1 = IN_HEIGHT-1, WC0 = 0, WC1 = IN_WIDTH-1;
`else
    localparam int WR0 = 1, WR1 = IN_HEIGHT-2, WC0 = 1, WC1 = IN_WIDTH-2;
`endif
    localparam logic [CW-1:0] WR0_L = CW'(WR0);
    localparam logic [CW-1:0] WR1_L = CW'(WR1);
    localparam logic [CW-1:0] WC0_L = CW'(WC0);
    localparam logic [CW-1:0] WC1_L = CW'(WC1);
    localparam logic [CW-1:0] XL_L  = CW'(IN_WIDTH-1);
    localparam logic [CW-1:0] YL_L  = CW'(IN_HEIGHT-1);

    // Line buffer. Frame row r lives in slot r%3. It is never reset: a window
    // only becomes eligible once all of its in-frame sources were written.
    logic [PW-1:0]   lb [3][IN_WIDTH];

    logic [CW-1:0]   pr, pc;        // next pixel position to accept
    logic [1:0]      ps;            // line-buffer slot of row pr
    logic [CW-1:0]   acc, acc_n;    // pixels accepted in this frame
    logic [CW-1:0]   wr, wc;        // window currently presented / pending
    logic [CW-1:0]   wr_n, wc_n;
    logic            accept, consume, frame_end, elig, elig_n;
    logic [9*PW-1:0] win_n;

    // Raster index of the pixel whose arrival completes window (r,c).
    function automatic logic [CW-1:0] need_idx(input logic [CW-1:0] r,
                                               input logic [CW-1:0] c);
        int nr, nc;
        nr = int'(r) + 1;
        nc = int'(c) + 1;
        if (nr > IN_HEIGHT-1) nr = IN_HEIGHT-1;
        if (nc > IN_WIDTH-1)  nc = IN_WIDTH-1;
        return CW'(nr*IN_WIDTH + nc);
    endfunction

    // A pending eligible window blocks input. This keeps the buffer safe,
    // because no pixel can overrun rows the pending window still reads.
    assign elig    = need_idx(wr, wc) < acc;
    assign i_ready = !elig;
    assign accept  = i_valid && i_ready;
    assign consume = o_valid && pe_ack;

    // Window pointer advance, frame wrap and eligibility of the next window.
    always_comb begin
        wr_n      = wr;
        wc_n      = wc;
        frame_end = 1'b0;
        if (consume) begin
            if (wr == WR1_L && wc == WC1_L) begin
                wr_n      = WR0_L;
                wc_n      = WC0_L;
                frame_end = 1'b1;
            end else if (wc == WC1_L) begin
                wc_n = WC0_L;
                wr_n = wr + 1'b1;
            end else begin
                wc_n = wc + 1'b1;
            end
        end
        acc_n  = frame_end ? '0 : acc + CW'(accept);
        elig_n = need_idx(wr_n, wc_n) < acc_n;
    end

    // Gather the nine taps of window (wr_n,wc_n). The pixel being written on
    // this edge is forwarded straight from i_data.
    for (genvar t = 0; t < 9; t++) begin : g_tap
        localparam int KY = t / 3;
        localparam int KX = t % 3;
        logic [PW-1:0] tap;
        // Zero for out-of-frame sources, otherwise bypass or buffer read.
        always_comb begin
            int sr, sc;
            sr  = int'(wr_n) + KY - 1;
            sc  = int'(wc_n) + KX - 1;
            tap = '0;
            if (sr >= 0 && sr < IN_HEIGHT && sc >= 0 && sc < IN_WIDTH) begin
                if (accept && sr == int'(pr) && sc == int'(pc))
                    tap = i_data;
                else
                    tap = lb[2'(sr % 3)][XW'(sc)];
            end
        end
        assign win_n[t*PW +: PW] = tap;
    end

    // Line-buffer write on every accepted pixel.
    always_ff @(posedge clk) begin
        if (accept) lb[ps][XW'(pc)] <= i_data;
    end

    // Counters and registered window output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr      <= '0;
            pc      <= '0;
            ps      <= '0;
            acc     <= '0;
            wr      <= WR0_L;
            wc      <= WC0_L;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            acc     <= acc_n;
            wr      <= wr_n;
            wc      <= wc_n;
            o_valid <= elig_n;
            if (elig_n) o_data <= win_n;
            if (accept) begin
                if (pc == XL_L) begin
                    pc <= '0;
                    if (pr == YL_L) begin
                        pr <= '0;
                        ps <= '0;
                    end else begin
                        pr <= pr + 1'b1;
                        ps <= (ps == 2'd2) ? 2'd0 : ps + 2'd1;
                    end
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_incha_window.sv
// Directed bench for pe_incha_window. It covers 3x3 with padding when
// PE_INCHA_WINDOW_PADDING_EN is defined, and 4x4 interior-only otherwise.
module tb_pe_incha_window;
`ifdef PE_INCHA_WINDOW_PADDING_EN
    localparam int W = 3, H = 3;
    localparam int WR0 = 0, WR1 = 2, WC0 = 0, WC1 = 2;
    localparam int TRIG = 4;        // window (0,0) completes at pixel (1,1)
`else
    localparam int W = 4, H = 4;
    localparam int WR0 = 1, WR1 = 2, WC0 = 1, WC1 = 2;
    localparam int TRIG = 10;       // window (1,1) completes at pixel (2,2)
`endif
    localparam int C  = 2;
    localparam int PW = 8*C;
    localparam int DW = 9*PW;
    localparam int N  = W*H;
    localparam int NWC = WC1-WC0+1;
    localparam int NW = (WR1-WR0+1)*NWC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] i_data;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          pe_ack;

    int checks = 0;
    int failures = 0;

    pe_incha_window #(.IN_WIDTH(W), .IN_HEIGHT(H), .IN_CHANNEL(C)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .pe_ack(pe_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pix(input int r, input int x);
        logic [PW-1:0] v;
        for (int c = 0; c < C; c++) v[8*c +: 8] = 8'(16*r + 4*x + c + 1);
        return v;
    endfunction

    // Expected k-th emitted window, built from the pixel formula.
    function automatic logic [DW-1:0] exp_win(input int k);
        logic [DW-1:0] v;
        int wr, wc, sr, sc;
        wr = WR0 + k / NWC;
        wc = WC0 + k % NWC;
        v  = '0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                sr = wr + ky - 1;
                sc = wc + kx - 1;
                if (sr >= 0 && sr < H && sc >= 0 && sc < W)
                    v[(ky*3+kx)*PW +: PW] = pix(sr, sc);
            end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Streams one frame, optionally holding pe_ack low for `hold` cycles on
    // the first window, and optionally stopping after stop_px accepted pixels.
    task automatic run_frame(input int hold, input int stop_px);
        int px = 0, k = 0, cyc = 0, last_acc = -10, hold_left = hold;
        bit seen = 0;
        while (k < NW && (stop_px < 0 || px < stop_px) && cyc < 400) begin
            @(negedge clk);
            i_valid = (px < N);
            i_data  = (px < N) ? pix(px / W, px % W) : '0;
            #1;
            pe_ack = o_valid && (hold_left == 0);
            if (o_valid) begin
                if (!seen) begin
                    seen = 1;
                    chk("first_latency", DW'(cyc), DW'(last_acc + 1));
                    chk("first_px_count", DW'(px), DW'(TRIG + 1));
                end
                chk($sformatf("win%0d_data", k), o_data, exp_win(k));
                chk("ready_low_while_valid", DW'(i_ready), DW'(0));
`ifdef PE_INCHA_WINDOW_PADDING_EN
                if (k == 0) begin
                    chk("w00_word8", DW'(o_data[8*8 +: 8]), DW'(8'h01));
                    chk("w00_word9", DW'(o_data[9*8 +: 8]), DW'(8'h02));
                    chk("w00_word16", DW'(o_data[16*8 +: 8]), DW'(8'h15));
                end
                if (k == NW-1) begin
                    chk("w22_word8", DW'(o_data[8*8 +: 8]), DW'(8'h29));
                    chk("w22_word16", DW'(o_data[16*8 +: 8]), DW'(8'h00));
                end
`else
                if (k == 0) begin
                    chk("w11_word0", DW'(o_data[0 +: 8]), DW'(8'h01));
                    chk("w11_word8", DW'(o_data[8*8 +: 8]), DW'(8'h15));
                end
`endif
                if (pe_ack) k++;
                else hold_left--;
            end
            if (i_valid && i_ready) begin
                px++;
                last_acc = cyc;
            end
            cyc++;
            @(posedge clk);
        end
        if (cyc >= 400) chk("frame_timeout", DW'(k), DW'(NW));
        if (stop_px < 0) begin
            chk("all_pixels_taken", DW'(px), DW'(N));
            @(negedge clk);
            i_valid = 1'b0;
            pe_ack  = 1'b0;
            #1;
            chk("end_o_valid", DW'(o_valid), DW'(0));
            chk("end_i_ready", DW'(i_ready), DW'(1));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        pe_ack  = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_o_valid", DW'(o_valid), DW'(0));
        chk("rst_o_data", o_data, '0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_i_ready", DW'(i_ready), DW'(1));

        // Free-running frame, then a frame with a 10-cycle stall.
        run_frame(0, -1);
        run_frame(10, -1);

        // Reset mid-frame with a window pending, then a clean restart.
        run_frame(0, TRIG + 1);
        @(negedge clk);
        i_valid = 1'b0;
        pe_ack  = 1'b0;
        #1;
        chk("pre_rst_o_valid", DW'(o_valid), DW'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", DW'(o_valid), DW'(0));
        chk("midrst_o_data", o_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_i_ready", DW'(i_ready), DW'(1));
        run_frame(0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
